// File: rtl/seq_cla_addsub_pkg.sv
// Shared definitions for the multi-cycle carry-lookahead adder/subtractor.
// Latency: n/a (constants, types and pure helper functions only).
// Backpressure: n/a.
//
// Contents: op encodings, FSM state type, default geometry and the derived
// slice count, plus helpers that map an op onto effective operand/carry.
package seq_cla_addsub_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_ADC = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_SBB = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_BLOCK = 8;

    // Number of BLOCK-bit slices processed per operation.
    function automatic int nchunk_of(input int width, input int block);
        return width / block;
    endfunction

    localparam int NCHUNK = nchunk_of(DEF_WIDTH, DEF_BLOCK);

    // Subtract ops feed the adder with ~b.
    function automatic logic is_sub(input logic [1:0] op);
        return (op == OP_SUB) || (op == OP_SBB);
    endfunction

    // Carry injected at the LSB: SUB adds 1 to complete two's complement,
    // SBB adds ~borrow so that a borrow-in of 1 subtracts one more.
    function automatic logic eff_cin(input logic [1:0] op, input logic cin);
        logic c;
        case (op)
            OP_ADD:  c = 1'b0;
            OP_ADC:  c = cin;
            OP_SUB:  c = 1'b1;
            default: c = ~cin;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/seq_cla_addsub_cla_block.sv
// Combinational BLOCK-bit carry-lookahead adder slice (group G/P tree).
// Latency: 0 cycles, purely combinational.
// Backpressure: n/a.
//
// Ports: x, y  - BLOCK-bit addends
//        ci    - carry into bit 0
//        z     - BLOCK-bit sum
//        co    - carry out of the top bit
//        c_msb - carry into the top bit (for signed overflow)
module seq_cla_addsub_cla_block
    import seq_cla_addsub_pkg::*;
#(
    parameter int BLOCK = 8
) (
    input  logic [BLOCK-1:0] x,
    input  logic [BLOCK-1:0] y,
    input  logic             ci,
    output logic [BLOCK-1:0] z,
    output logic             co,
    output logic             c_msb
);

    localparam int LEVELS = $clog2(BLOCK);

    logic [BLOCK-1:0] hp;      // bit half-sums
    logic [BLOCK-1:0] gg, pp;  // group generate/propagate, level by level
    logic [BLOCK-1:0] gn, pn;
    logic [BLOCK-1:0] carries; // carry into each bit

    // Each level doubles the span of every group: group [i-2d+1 .. i] is the
    // merge of [i-d+1 .. i] and [i-2d+1 .. i-d]. After LEVELS levels gg[i]
    // is the generate of bits [0 .. i]. The carry-in is folded into bit 0's
    // generate so that gg[i] is directly the carry out of bit i.
    always_comb begin
        hp = x ^ y;
        gg = x & y;
        pp = hp;
        gg[0] = gg[0] | (pp[0] & ci);
        gn = gg;
        pn = pp;
        for (int l = 0; l < LEVELS; l++) begin
            gn = gg;
            pn = pp;
            for (int i = 0; i < BLOCK; i++) begin
                if (i >= (1 << l)) begin
                    gn[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
                    pn[i] = pp[i] & pp[i - (1 << l)];
                end
            end
            gg = gn;
            pp = pn;
        end
        carries = {gg[BLOCK-2:0], ci};
    end

    assign z     = hp ^ carries;
    assign co    = gg[BLOCK-1];
    assign c_msb = carries[BLOCK-1];

endmodule

// File: rtl/seq_cla_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor, one BLOCK-bit lookahead slice/cycle.
// Latency: accept at edge E, out_valid high after edge E+WIDTH/BLOCK.
// Backpressure: in_ready only in IDLE; result/flags held while !out_ready.
//
// Ports: clk, rst_n (async, active-low)
//        in_valid/in_ready   - operand handshake (op, a, b, cin)
//        out_valid/out_ready - result handshake
//        result, carry, overflow, zero, negative - registered outputs
module seq_cla_addsub
    import seq_cla_addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    // WIDTH must be a multiple of BLOCK; BLOCK a power of two >= 2.
    localparam int NCH  = nchunk_of(WIDTH, BLOCK);
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, b_q;   // a and effective b, latched at accept
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] res_nxt;
    logic             cy_q;       // inter-slice carry register
    logic [IDXW-1:0]  idx_q;
    logic             carry_q, overflow_q, zero_q, negative_q;

    logic [BLOCK-1:0] slice_x, slice_y, slice_z;
    logic             slice_co, slice_cmsb;
    logic             last;

    assign last    = (idx_q == LAST_IDX);
    assign slice_x = a_q[idx_q*BLOCK +: BLOCK];
    assign slice_y = b_q[idx_q*BLOCK +: BLOCK];

    seq_cla_addsub_cla_block #(
        .BLOCK (BLOCK)
    ) u_cla (
        .x     (slice_x),
        .y     (slice_y),
        .ci    (cy_q),
        .z     (slice_z),
        .co    (slice_co),
        .c_msb (slice_cmsb)
    );

    // Result with the current slice merged in; used both for the register
    // update and so the flags on the final slice see the complete result.
    always_comb begin
        res_nxt = result_q;
        res_nxt[idx_q*BLOCK +: BLOCK] = slice_z;
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)  state_d = ST_BUSY;
            ST_BUSY: if (last)      state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: in_ready  = 1'b1;
            ST_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath. Nothing updates in DONE, which is what keeps the outputs
    // stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            cy_q       <= 1'b0;
            idx_q      <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= is_sub(op) ? ~b : b;
                        cy_q  <= eff_cin(op, cin);
                        idx_q <= '0;
                    end
                end
                ST_BUSY: begin
                    result_q <= res_nxt;
                    cy_q     <= slice_co;
                    idx_q    <= last ? '0 : idx_q + 1'b1;
                    if (last) begin
                        carry_q    <= slice_co;
                        overflow_q <= slice_co ^ slice_cmsb;
                        zero_q     <= ~|res_nxt;
                        negative_q <= res_nxt[WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign result   = result_q;
    assign carry    = carry_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;
    assign negative = negative_q;

endmodule

// File: tb/tb_seq_cla_addsub.sv
module tb_seq_cla_addsub;
    import seq_cla_addsub_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DUT 0: WIDTH=32 BLOCK=8
    logic        iv0, ir0, ov0, ordy0, ci0, cy0, vf0, zf0, nf0;
    logic [1:0]  op0;
    logic [31:0] a0, b0, r0;
    // DUT 1: WIDTH=8 BLOCK=8
    logic        iv1, ir1, ov1, ordy1, ci1, cy1, vf1, zf1, nf1;
    logic [1:0]  op1;
    logic [7:0]  a1, b1, r1;
    // DUT 2: WIDTH=16 BLOCK=4
    logic        iv2, ir2, ov2, ordy2, ci2, cy2, vf2, zf2, nf2;
    logic [1:0]  op2;
    logic [15:0] a2, b2, r2;

    seq_cla_addsub #(.WIDTH(32), .BLOCK(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .op(op0),
        .a(a0), .b(b0), .cin(ci0), .out_valid(ov0), .out_ready(ordy0),
        .result(r0), .carry(cy0), .overflow(vf0), .zero(zf0), .negative(nf0));
    seq_cla_addsub #(.WIDTH(8), .BLOCK(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .op(op1),
        .a(a1), .b(b1), .cin(ci1), .out_valid(ov1), .out_ready(ordy1),
        .result(r1), .carry(cy1), .overflow(vf1), .zero(zf1), .negative(nf1));
    seq_cla_addsub #(.WIDTH(16), .BLOCK(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .op(op2),
        .a(a2), .b(b2), .cin(ci2), .out_valid(ov2), .out_ready(ordy2),
        .result(r2), .carry(cy2), .overflow(vf2), .zero(zf2), .negative(nf2));

    typedef struct packed {
        logic [31:0] r;
        logic c, v, z, n;
    } exp_t;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int d, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic ci, input logic vld);
        case (d)
            0: begin op0 = o; a0 = x;       b0 = y;       ci0 = ci; iv0 = vld; end
            1: begin op1 = o; a1 = x[7:0];  b1 = y[7:0];  ci1 = ci; iv1 = vld; end
            default: begin op2 = o; a2 = x[15:0]; b2 = y[15:0]; ci2 = ci; iv2 = vld; end
        endcase
    endtask

    task automatic set_ordy(input int d, input logic v);
        case (d)
            0: ordy0 = v;
            1: ordy1 = v;
            default: ordy2 = v;
        endcase
    endtask

    task automatic get(input int d, output logic [31:0] r, output logic c, output logic v,
                       output logic z, output logic n, output logic irdy, output logic ovl);
        case (d)
            0: begin r = r0; c = cy0; v = vf0; z = zf0; n = nf0; irdy = ir0; ovl = ov0; end
            1: begin r = {24'h0, r1}; c = cy1; v = vf1; z = zf1; n = nf1; irdy = ir1; ovl = ov1; end
            default: begin r = {16'h0, r2}; c = cy2; v = vf2; z = zf2; n = nf2; irdy = ir2; ovl = ov2; end
        endcase
    endtask

    // Issue one operation; inputs are scrambled right after the accept edge.
    // Returns edges from accept until out_valid (bounded at 40).
    task automatic run(input int d, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic ci, output int lat);
        logic [31:0] r;
        logic c, v, z, n, irdy, ovl;
        drive(d, o, x, y, ci, 1'b1);
        @(posedge clk); #1;
        drive(d, ~o, ~x, ~y, ~ci, 1'b0);
        lat = 0;
        get(d, r, c, v, z, n, irdy, ovl);
        while (!ovl && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            get(d, r, c, v, z, n, irdy, ovl);
        end
    endtask

    task automatic check_out(input int d, input string tag, input exp_t e);
        logic [31:0] r;
        logic c, v, z, n, irdy, ovl;
        get(d, r, c, v, z, n, irdy, ovl);
        chk({tag, "_valid"}, 64'(ovl), 64'(1'b1));
        chk({tag, "_result"}, 64'(r), 64'(e.r));
        chk({tag, "_carry"}, 64'(c), 64'(e.c));
        chk({tag, "_ovf"}, 64'(v), 64'(e.v));
        chk({tag, "_zero"}, 64'(z), 64'(e.z));
        chk({tag, "_neg"}, 64'(n), 64'(e.n));
        chk({tag, "_inrdy"}, 64'(irdy), 64'(1'b0));
    endtask

    task automatic release_out(input int d, input string tag);
        logic [31:0] r;
        logic c, v, z, n, irdy, ovl;
        set_ordy(d, 1'b1);
        @(posedge clk); #1;
        set_ordy(d, 1'b0);
        get(d, r, c, v, z, n, irdy, ovl);
        chk({tag, "_rel_valid"}, 64'(ovl), 64'(1'b0));
        chk({tag, "_rel_inrdy"}, 64'(irdy), 64'(1'b1));
    endtask

    // Behavioural reference: wide addition with explicit per-op operands.
    function automatic exp_t model(input int w, input logic [1:0] o, input logic [31:0] x,
                                   input logic [31:0] y, input logic ci);
        logic [32:0] mask, xm, ym, s;
        exp_t e;
        mask = (33'h1 << w) - 33'h1;
        xm = {1'b0, x} & mask;
        ym = {1'b0, y} & mask;
        case (o)
            OP_ADD:  s = xm + ym;
            OP_ADC:  s = xm + ym + {32'h0, ci};
            OP_SUB:  s = xm + (~ym & mask) + 33'h1;
            default: s = xm + (~ym & mask) + {32'h0, ~ci};
        endcase
        e.c = s[w];
        e.r = s[31:0] & mask[31:0];
        if (o == OP_SUB || o == OP_SBB) ym = ~ym & mask;
        e.v = (xm[w-1] == ym[w-1]) && (e.r[w-1] != xm[w-1]);
        e.z = (e.r == 32'h0);
        e.n = e.r[w-1];
        return e;
    endfunction

    function automatic logic [31:0] corner(input int w, input int k);
        logic [31:0] one;
        one = 32'h1;
        case (k)
            0: return 32'h0;
            1: return one;
            2: return (one << (w - 1)) - one;
            3: return one << (w - 1);
            default: return (one << w) - one;
        endcase
    endfunction

    initial begin
        int lat;
        logic [31:0] r;
        logic c, v, z, n, irdy, ovl;

        rst_n = 1'b0;
        drive(0, OP_ADD, 0, 0, 0, 0);
        drive(1, OP_ADD, 0, 0, 0, 0);
        drive(2, OP_ADD, 0, 0, 0, 0);
        ordy0 = 0; ordy1 = 0; ordy2 = 0;
        #22 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state
        get(0, r, c, v, z, n, irdy, ovl);
        chk("rst_valid", 64'(ovl), 64'(1'b0));
        chk("rst_inrdy", 64'(irdy), 64'(1'b1));
        chk("rst_result", 64'(r), 64'h0);
        chk("rst_flags", 64'({c, v, z, n}), 64'h0);

        // ADD wraparound, 4-cycle latency
        run(0, OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b0, lat);
        chk("add_lat", 64'(lat), 64'd4);
        check_out(0, "add", '{r: 32'h0, c: 1'b1, v: 1'b0, z: 1'b1, n: 1'b0});

        // Backpressure: hold 3 cycles, in_valid pulse must be ignored
        for (int k = 0; k < 3; k++) begin
            if (k == 1) drive(0, OP_SUB, 32'h55, 32'h22, 1'b0, 1'b1);
            @(posedge clk); #1;
            drive(0, OP_ADD, 0, 0, 0, 0);
            check_out(0, "bp", '{r: 32'h0, c: 1'b1, v: 1'b0, z: 1'b1, n: 1'b0});
        end
        release_out(0, "bp");

        run(0, OP_SUB, 32'h8000_0000, 32'h1, 1'b0, lat);
        chk("sub_lat", 64'(lat), 64'd4);
        check_out(0, "sub", '{r: 32'h7FFF_FFFF, c: 1'b1, v: 1'b1, z: 1'b0, n: 1'b0});
        release_out(0, "sub");

        run(0, OP_ADC, 32'h7FFF_FFFF, 32'h0, 1'b1, lat);
        check_out(0, "adc", '{r: 32'h8000_0000, c: 1'b0, v: 1'b1, z: 1'b0, n: 1'b1});
        release_out(0, "adc");

        run(0, OP_SBB, 32'h5, 32'h3, 1'b1, lat);
        check_out(0, "sbb", '{r: 32'h1, c: 1'b1, v: 1'b0, z: 1'b0, n: 1'b0});
        release_out(0, "sbb");

        run(0, OP_SUB, 32'h3, 32'h5, 1'b0, lat);
        check_out(0, "sub_neg", '{r: 32'hFFFF_FFFE, c: 1'b0, v: 1'b0, z: 1'b0, n: 1'b1});
        release_out(0, "sub_neg");

        // cin ignored for plain ADD
        run(0, OP_ADD, 32'h1, 32'h1, 1'b1, lat);
        check_out(0, "add_cin", '{r: 32'h2, c: 1'b0, v: 1'b0, z: 1'b0, n: 1'b0});
        release_out(0, "add_cin");

        // Reset in BUSY with idx == 2
        drive(0, OP_ADD, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(0, OP_ADD, 0, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        get(0, r, c, v, z, n, irdy, ovl);
        chk("mid_rst_valid", 64'(ovl), 64'(1'b0));
        chk("mid_rst_result", 64'(r), 64'h0);
        chk("mid_rst_flags", 64'({c, v, z, n}), 64'h0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        get(0, r, c, v, z, n, irdy, ovl);
        chk("mid_rst_inrdy", 64'(irdy), 64'(1'b1));
        chk("mid_rst_valid2", 64'(ovl), 64'(1'b0));
        run(0, OP_ADD, 32'h1, 32'h1, 1'b0, lat);
        chk("post_rst_lat", 64'(lat), 64'd4);
        check_out(0, "post_rst", '{r: 32'h2, c: 1'b0, v: 1'b0, z: 1'b0, n: 1'b0});
        release_out(0, "post_rst");

        // 8/8 and 16/4 configurations against the reference model
        for (int d = 1; d < 3; d++) begin
            int w;
            w = (d == 1) ? 8 : 16;
            for (int i = 0; i < 150; i++) begin
                logic [1:0]  o;
                logic [31:0] x, y;
                logic        ci;
                o  = 2'(i % 4);
                ci = 1'($urandom_range(0, 1));
                if (i < 100) begin
                    x = corner(w, (i / 4) % 5);
                    y = corner(w, (i / 20) % 5);
                end else begin
                    x = $urandom;
                    y = $urandom;
                end
                run(d, o, x, y, ci, lat);
                chk((d == 1) ? "w8_lat" : "w16_lat", 64'(lat), (d == 1) ? 64'd1 : 64'd4);
                check_out(d, (d == 1) ? "w8" : "w16", model(w, o, x, y, ci));
                release_out(d, (d == 1) ? "w8" : "w16");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
